// File: rtl/image_mem_responder.sv
// Word-addressed image memory shared by a host stream port and an accelerator.
// Sequences load -> accelerator run -> dump of the output region -> done pulse.
module image_mem_responder #(
  parameter int DEPTH     = 65536,
  parameter int IN_WORDS  = 25344,
  parameter int OUT_BASE  = 25344,
  parameter int OUT_WORDS = 25344
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_go,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done,
  output logic        acc_start,
  input  logic        acc_finish,
  input  logic [15:0] acc_addr,
  input  logic        acc_en,
  input  logic        acc_we,
  input  logic [31:0] acc_dataW,
  output logic [31:0] acc_dataR
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 17;
  localparam logic [CW-1:0] IN_LAST    = CW'(IN_WORDS - 1);
  localparam logic [CW-1:0] OUT_TOTAL  = CW'(OUT_WORDS);
  localparam logic [AW-1:0] OUT_BASE_A = AW'(OUT_BASE);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP, DONE} state_t;

  state_t        state_reg;
  logic [CW-1:0] ld_cnt_reg;
  logic [CW-1:0] iss_cnt_reg;
  logic          in_ready_reg;
  logic          out_valid_reg;
  logic          done_reg;
  logic          acc_start_reg;
  logic [31:0]   acc_data_r_reg;
  logic [31:0]   out_data_reg;

  logic [31:0]   mem [DEPTH];

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW-1:0] rd_addr;
  logic          acc_rd;
  logic          dump_rd;
  logic          out_hs;

  // Only the low address bits select a word; upper bits wrap away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^acc_addr;

  assign out_hs = out_valid_reg & out_ready;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    acc_rd  = 1'b0;
    dump_rd = 1'b0;
    case (state_reg)
      LOAD: begin
        wr_en   = in_valid & in_ready_reg;
        wr_addr = ld_cnt_reg[AW-1:0];
        wr_data = in_data;
      end
      RUN: begin
        wr_en   = acc_en & acc_we;
        wr_addr = acc_addr[AW-1:0];
        wr_data = acc_dataW;
        acc_rd  = acc_en & ~acc_we;
        rd_addr = acc_addr[AW-1:0];
      end
      DUMP: begin
        // Refill the output register on the first cycle or whenever it drains.
        dump_rd = (iss_cnt_reg != OUT_TOTAL) && (!out_valid_reg || out_ready);
        rd_addr = OUT_BASE_A + iss_cnt_reg[AW-1:0];
      end
      default: ;
    endcase
  end

  // Memory array has no reset so contents survive an aborted job.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_data_r_reg <= '0;
      out_data_reg   <= '0;
    end else begin
      if (acc_rd) begin
        acc_data_r_reg <= mem[rd_addr];
      end
      if (dump_rd) begin
        out_data_reg <= mem[rd_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ld_cnt_reg    <= '0;
      iss_cnt_reg   <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      acc_start_reg <= 1'b0;
    end else begin
      done_reg      <= 1'b0;
      acc_start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_go) begin
            state_reg    <= LOAD;
            ld_cnt_reg   <= '0;
            in_ready_reg <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid && in_ready_reg) begin
            ld_cnt_reg <= ld_cnt_reg + CW'(1);
            if (ld_cnt_reg == IN_LAST) begin
              state_reg     <= RUN;
              in_ready_reg  <= 1'b0;
              acc_start_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          // acc_start_reg high marks the first RUN cycle, where finish is ignored.
          if (!acc_start_reg && acc_finish) begin
            state_reg     <= DUMP;
            iss_cnt_reg   <= '0;
            out_valid_reg <= 1'b0;
          end
        end
        DUMP: begin
          if (dump_rd) begin
            out_valid_reg <= 1'b1;
            iss_cnt_reg   <= iss_cnt_reg + CW'(1);
          end else if (out_hs) begin
            out_valid_reg <= 1'b0;
            if (iss_cnt_reg == OUT_TOTAL) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign acc_start = acc_start_reg;
  assign acc_dataR = acc_data_r_reg;

endmodule

// File: tb/tb_image_mem_responder.sv
// Bench for image_mem_responder: vector table for accelerator accesses, hand
// sequences for load/dump corners, random traffic against a word-array model.
module tb_image_mem_responder;

  localparam int DEPTH = 16;
  localparam int IN_W  = 4;
  localparam int OBASE = 8;
  localparam int OUT_W = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_go = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic        acc_start;
  logic        acc_finish = 1'b0;
  logic [15:0] acc_addr = '0;
  logic        acc_en = 1'b0;
  logic        acc_we = 1'b0;
  logic [31:0] acc_dataW = '0;
  logic [31:0] acc_dataR;

  image_mem_responder #(
    .DEPTH(DEPTH), .IN_WORDS(IN_W), .OUT_BASE(OBASE), .OUT_WORDS(OUT_W)
  ) dut (
    .clk(clk), .reset(reset), .cmd_go(cmd_go),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .acc_start(acc_start), .acc_finish(acc_finish),
    .acc_addr(acc_addr), .acc_en(acc_en), .acc_we(acc_we),
    .acc_dataW(acc_dataW), .acc_dataR(acc_dataR)
  );

  always #5 clk = ~clk;

  // Reference model: plain word array indexed by address modulo DEPTH.
  logic [31:0] model [DEPTH];
  bit          known [DEPTH];
  logic [31:0] last_rd = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } acc_vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic fail_timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out, got no completion expected completion", nm);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_in_ready"}, in_ready, 0);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_acc_start"}, acc_start, 0);
    chk({nm, "_acc_dataR"}, acc_dataR, 0);
    chk({nm, "_out_data"}, out_data, 0);
  endtask

  task automatic load_job(input bit gaps, input bit settle);
    int idx;
    int guard;
    bit hs;
    logic [31:0] w;
    idx = 0;
    guard = 0;
    cmd_go = 1'b1;
    step();
    cmd_go = 1'b0;
    chk("load_in_ready", in_ready, 1);
    chk("load_busy", busy, 1);
    while (idx < IN_W && guard < 100) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      w = gaps ? $urandom : 32'h11111111 * (idx + 1);
      in_data = w;
      hs = in_valid && in_ready;
      step();
      guard++;
      if (hs) begin
        model[idx] = w;
        known[idx] = 1'b1;
        idx++;
      end
      if (idx < IN_W) begin
        chk("load_ready_hold", in_ready, 1);
        chk("load_no_start", acc_start, 0);
      end
    end
    in_valid = 1'b0;
    if (idx < IN_W) begin
      fail_timeout("load");
    end
    chk("acc_start_pulse", acc_start, 1);
    chk("run_in_ready", in_ready, 0);
    if (settle) begin
      step();
      chk("acc_start_drop", acc_start, 0);
    end
  endtask

  task automatic rand_ops(input int n);
    int r;
    int k;
    logic [15:0] a;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 2);
      if (r == 0) begin
        a = 16'($urandom);
        d = $urandom;
        acc_en = 1'b1; acc_we = 1'b1; acc_addr = a; acc_dataW = d;
        step();
        model[a % DEPTH] = d;
        known[a % DEPTH] = 1'b1;
      end else if (r == 1) begin
        k = $urandom_range(0, DEPTH - 1);
        if (!known[k]) k = k % IN_W;
        a = 16'(k + DEPTH * $urandom_range(0, 4095));
        acc_en = 1'b1; acc_we = 1'b0; acc_addr = a;
        step();
        last_rd = model[k];
        chk("rand_read", acc_dataR, last_rd);
      end else begin
        acc_en = 1'b0; acc_we = 1'($urandom); acc_addr = 16'($urandom);
        step();
        chk("rand_hold", acc_dataR, last_rd);
      end
    end
    acc_en = 1'b0;
    acc_we = 1'b0;
  endtask

  task automatic enter_dump();
    acc_en = 1'b0;
    acc_finish = 1'b1;
    step();
    acc_finish = 1'b0;
    chk("dump_first_latency", out_valid, 0);
    chk("dump_busy", busy, 1);
  endtask

  task automatic collect(input int mode, output int steps);
    int got;
    bit holding;
    logic [31:0] held;
    got = 0;
    holding = 1'b0;
    held = '0;
    steps = 0;
    while (got < OUT_W && steps < 60) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (steps % 2 == 1);
        default: out_ready = 1'($urandom);
      endcase
      if (out_valid && out_ready) begin
        chk("dump_word", out_data, model[(OBASE + got) % DEPTH]);
        got++;
      end else if (out_valid) begin
        held = out_data;
        holding = 1'b1;
      end
      step();
      steps++;
      if (holding) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held);
        holding = 1'b0;
      end
    end
    out_ready = 1'b0;
    if (got < OUT_W) begin
      fail_timeout("dump");
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_valid_low", out_valid, 0);
    step();
    chk("done_drop", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    acc_vec_t tbl [10];
    int steps;

    for (int i = 0; i < DEPTH; i++) begin
      model[i] = '0;
      known[i] = 1'b0;
    end

    tbl[0] = '{1'b1, 16'd9,  32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b0, 16'd9,  32'h0, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 16'd25, 32'h0, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 16'd8,  32'hA0, 32'h0};
    tbl[4] = '{1'b1, 16'd9,  32'hA1, 32'h0};
    tbl[5] = '{1'b1, 16'd10, 32'hA2, 32'h0};
    tbl[6] = '{1'b1, 16'd11, 32'hA3, 32'h0};
    tbl[7] = '{1'b0, 16'd0,  32'h0, 32'h11111111};
    tbl[8] = '{1'b0, 16'd26, 32'h0, 32'hA2};
    tbl[9] = '{1'b0, 16'd3,  32'h0, 32'h44444444};

    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk_reset_outputs("reset");

    // Job 1: fixed pattern load, vector table, ignored cmd_go, streaming dump.
    load_job(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      acc_en = 1'b1;
      acc_we = tbl[i].we;
      acc_addr = tbl[i].addr;
      acc_dataW = tbl[i].data;
      step();
      if (tbl[i].we) begin
        model[tbl[i].addr % DEPTH] = tbl[i].data;
        known[tbl[i].addr % DEPTH] = 1'b1;
      end else begin
        last_rd = tbl[i].exp;
        chk($sformatf("tbl_read_%0d", i), acc_dataR, tbl[i].exp);
      end
    end
    acc_en = 1'b0;
    acc_we = 1'b0;
    step();
    chk("tbl_hold", acc_dataR, 32'h44444444);
    cmd_go = 1'b1;
    step();
    cmd_go = 1'b0;
    chk("go_in_run_busy", busy, 1);
    chk("go_in_run_ready", in_ready, 0);
    chk("go_in_run_start", acc_start, 0);
    acc_en = 1'b1; acc_we = 1'b0; acc_addr = 16'd9;
    step();
    acc_en = 1'b0;
    last_rd = 32'hA1;
    chk("go_in_run_read", acc_dataR, 32'hA1);
    enter_dump();
    collect(0, steps);
    chk("dump_stream_cycles", 32'(steps), 32'd5);

    // Accelerator port must have no effect outside RUN.
    acc_en = 1'b1; acc_we = 1'b1; acc_addr = 16'd8; acc_dataW = 32'hBAD0BAD0;
    step();
    acc_we = 1'b0; acc_addr = 16'd9;
    step();
    acc_en = 1'b0;
    chk("idle_acc_ignored", acc_dataR, last_rd);

    // Job 2: gapped load, finish held from the first RUN cycle, toggling ready.
    load_job(1'b1, 1'b0);
    acc_finish = 1'b1;
    step();
    chk("finish_r1_start_drop", acc_start, 0);
    chk("finish_r1_ignored", out_valid, 0);
    step();
    acc_finish = 1'b0;
    chk("finish_r2_latency", out_valid, 0);
    collect(1, steps);

    // Job 3: random traffic, then reset in the middle of the dump.
    load_job(1'b1, 1'b1);
    rand_ops(40);
    enter_dump();
    out_ready = 1'b0;
    step();
    step();
    chk("pre_reset_valid", out_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    last_rd = '0;
    chk_reset_outputs("mid_dump_reset");

    // Job 4: fresh job after abort, random traffic and random ready.
    load_job(1'b1, 1'b1);
    rand_ops(40);
    enter_dump();
    collect(2, steps);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/image_mem_responder.md
IMAGE_MEM_RESPONDER -- requirements
Module: image_mem_responder

Interface
REQ-001 SHALL provide parameter DEPTH, 65536, memory size in 32-bit words (power of two, <= 65536).
REQ-002 SHALL provide parameter IN_WORDS, 25344, input image words (352x288 pixels, 4 pixels/word, 88 words/row).
REQ-003 SHALL provide parameter OUT_BASE, 25344, word address of first output-image word.
REQ-004 SHALL provide parameter OUT_WORDS, 25344, output image words.
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port cmd_go  in  1  host request to start a load/run/dump job.
REQ-008 SHALL have port in_valid  in  1, in_ready  out  1, in_data  in  32: host input-image stream.
REQ-009 SHALL have port out_valid  out  1, out_ready  in  1, out_data  out  32: host output-image stream.
REQ-010 SHALL have port busy  out  1 (not IDLE) and done  out  1 (one-cycle job-complete pulse).
REQ-011 SHALL have port acc_start  out  1  start pulse to accelerator.
REQ-012 SHALL have port acc_finish  in  1  accelerator completion level.
REQ-013 SHALL have ports acc_addr  in  16, acc_en  in  1, acc_we  in  1, acc_dataW  in  32: accelerator memory request (word address).
REQ-014 SHALL have port acc_dataR  out  32  read data to accelerator.

Function
REQ-015 SHALL implement states IDLE, LOAD, RUN, DUMP, DONE.
REQ-016 IDLE: cmd_go=1 -> LOAD, load counter cleared; cmd_go in any other state SHALL be ignored.
REQ-017 LOAD: in_ready=1; each cycle with in_valid&in_ready SHALL write in_data to word (counter) and increment counter; after word IN_WORDS-1 accepted -> RUN next cycle with in_ready=0.
REQ-018 RUN entry: acc_start=1 for exactly the first RUN cycle, 0 otherwise.
REQ-019 RUN: acc_en=1, acc_we=1 SHALL write acc_dataW to word acc_addr mod DEPTH at that edge.
REQ-020 RUN: acc_en=1, acc_we=0 SHALL present word acc_addr mod DEPTH on acc_dataR one cycle later (registered, 1-cycle latency); read of a word written the previous cycle returns new data.
REQ-021 acc_dataR SHALL hold its last value on cycles with no read; acc_en ignored outside RUN (no memory effect).
REQ-022 RUN: acc_finish=1 (sampled no earlier than second RUN cycle) -> DUMP, dump counters cleared.
REQ-023 DUMP: SHALL read words OUT_BASE..OUT_BASE+OUT_WORDS-1 in order; out_valid asserts one cycle after a read issue; out_data/out_valid SHALL stay stable until out_valid&out_ready.
REQ-024 DUMP: next read SHALL issue in the handshake cycle, so out_ready held high yields one word per cycle after a 1-cycle initial latency.
REQ-025 After last output word handshakes -> DONE; DONE asserts done=1 for one cycle -> IDLE.
REQ-026 Address arithmetic SHALL wrap modulo DEPTH; counters SHALL be wide enough for IN_WORDS/OUT_WORDS without overflow.
REQ-027 busy=1 in LOAD, RUN, DUMP, DONE; 0 in IDLE.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE, clear counters, and set in_ready, out_valid, busy, done, acc_start to 0 and acc_dataR, out_data to 0.
REQ-029 Reset mid-job SHALL abort immediately; memory contents SHALL be preserved; a later cmd_go starts a fresh job.

Verification (DEPTH=16, IN_WORDS=4, OUT_BASE=8, OUT_WORDS=4)
REQ-030 cmd_go, stream 0x11111111..0x44444444 with in_valid constant -> words 0..3 loaded, acc_start pulses once, exactly 1 cycle after 4th handshake.
REQ-031 RUN: write 0xDEADBEEF to addr 9, then read addr 9 next cycle -> acc_dataR=0xDEADBEEF one cycle after read; read addr 25 -> returns word 9 (wrap).
REQ-032 acc writes 0xA0..0xA3 to 8..11, acc_finish=1, out_ready=1 -> out_data A0,A1,A2,A3 on consecutive cycles, then done pulse, busy=0.
REQ-033 DUMP with out_ready toggling 1/0 -> each word held stable while out_ready=0, no word lost or duplicated.
REQ-034 in_valid gaps during LOAD -> only handshaked words written, counter stalls; cmd_go during RUN -> no effect.
REQ-035 reset asserted mid-DUMP -> next cycle all outputs 0, IDLE; new job reloads and dumps correctly.
